snake_body_engine: RTL

- Produces the game-status inputs consumed by the top-level game state machine: Collision, Length and per-cell snake occupancy (Cell_Snake).
- Holds the snake body as a ring buffer of cell indices plus an occupancy bitmap on a GRID_W x GRID_H board.
- Advances one cell per Tick while the game is running, and re-initialises while the game is in state I.

---
 rtl/snake_body_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/snake_body_engine.sv
// Snake body engine: ring buffer of body cells, occupancy bitmap and a move/collision FSM.
// Define WRAP_EN to make the board edges wrap instead of acting as walls.
module snake_body_engine #(
    parameter int GRID_W   = 15,
    parameter int GRID_H   = 15,
    parameter int MAX_LEN  = 225,
    parameter int INIT_LEN = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       q_I,
    input  logic       q_Run,
    input  logic       Tick,
    input  logic [1:0] Dir_In,
    input  logic [3:0] Food_X,
    input  logic [3:0] Food_Y,
    input  logic [3:0] Query_X,
    input  logic [3:0] Query_Y,
    output logic       Collision,
    output logic [7:0] Length,
    output logic       Food_Eaten,
    output logic [3:0] Head_X,
    output logic [3:0] Head_Y,
    output logic       Cell_Snake
);

    typedef enum logic [2:0] {S_INIT, S_WAIT, S_STEP, S_COMMIT, S_HALT} state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam int         HEAD_IDX  = (GRID_H / 2) * GRID_W + GRID_W / 2;
    localparam logic [7:0] LAST_PTR  = 8'(MAX_LEN - 1);

`ifdef WRAP_EN
    localparam bit WALLS_SOLID = 1'b0;
`else
    localparam bit WALLS_SOLID = 1'b1;
`endif

    state_t             state;
    logic [1:0]         cur_dir;
    logic [7:0]         head_ptr;
    logic [7:0]         tail_ptr;
    logic [MAX_LEN-1:0] bitmap;
    logic [7:0]         body [MAX_LEN];

    logic [3:0] next_x, next_y;
    logic [7:0] next_idx, tail_idx;
    logic       wall_hit, grow, occupied, self_hit;

    logic [3:0] step_x, step_y;
    logic [7:0] step_idx;
    logic       step_wall, step_grow, step_self;

    logic       query_ok;
    logic [7:0] query_idx;

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == LAST_PTR) ? 8'd0 : p + 8'd1;
    endfunction

    always_comb begin
        next_x   = Head_X;
        next_y   = Head_Y;
        wall_hit = 1'b0;
        case (cur_dir)
            DIR_UP: begin
                wall_hit = WALLS_SOLID && (Head_Y == 4'd0);
                next_y   = (Head_Y == 4'd0) ? 4'(GRID_H - 1) : Head_Y - 4'd1;
            end
            DIR_RIGHT: begin
                wall_hit = WALLS_SOLID && (Head_X == 4'(GRID_W - 1));
                next_x   = (Head_X == 4'(GRID_W - 1)) ? 4'd0 : Head_X + 4'd1;
            end
            DIR_DOWN: begin
                wall_hit = WALLS_SOLID && (Head_Y == 4'(GRID_H - 1));
                next_y   = (Head_Y == 4'(GRID_H - 1)) ? 4'd0 : Head_Y + 4'd1;
            end
            DIR_LEFT: begin
                wall_hit = WALLS_SOLID && (Head_X == 4'd0);
                next_x   = (Head_X == 4'd0) ? 4'(GRID_W - 1) : Head_X - 4'd1;
            end
        endcase
        next_idx = 8'(int'(next_y) * GRID_W + int'(next_x));
        tail_idx = body[tail_ptr];
        grow     = (next_x == Food_X) && (next_y == Food_Y);
        occupied = (next_idx < 8'(MAX_LEN)) ? bitmap[next_idx] : 1'b0;
        // The tail cell is vacated during a non-growing move, so stepping onto it is legal.
        self_hit = occupied && !(!grow && (next_idx == tail_idx));
    end

    always_comb begin
        query_ok   = (Query_X < 4'(GRID_W)) && (Query_Y < 4'(GRID_H));
        query_idx  = 8'(int'(Query_Y) * GRID_W + int'(Query_X));
        Cell_Snake = query_ok ? bitmap[query_idx] : 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_INIT;
            cur_dir    <= DIR_RIGHT;
            Collision  <= 1'b0;
            Food_Eaten <= 1'b0;
            Length     <= 8'd0;
            Head_X     <= 4'd0;
            Head_Y     <= 4'd0;
            bitmap     <= '0;
            head_ptr   <= 8'd0;
            tail_ptr   <= 8'd0;
            step_x     <= 4'd0;
            step_y     <= 4'd0;
            step_idx   <= 8'd0;
            step_wall  <= 1'b0;
            step_grow  <= 1'b0;
            step_self  <= 1'b0;
        end else begin
            Food_Eaten <= 1'b0;
            if (q_I || state == S_INIT) begin
                bitmap <= '0;
                for (int i = 0; i < INIT_LEN; i++)
                    bitmap[8'(HEAD_IDX - INIT_LEN + 1 + i)] <= 1'b1;
                Collision <= 1'b0;
                cur_dir   <= DIR_RIGHT;
                Length    <= 8'(INIT_LEN);
                head_ptr  <= 8'(INIT_LEN - 1);
                tail_ptr  <= 8'd0;
                Head_X    <= 4'(GRID_W / 2);
                Head_Y    <= 4'(GRID_H / 2);
                state     <= S_WAIT;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (Tick && q_Run) begin
                            if (Dir_In != (cur_dir ^ 2'd2))
                                cur_dir <= Dir_In;
                            state <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        step_x    <= next_x;
                        step_y    <= next_y;
                        step_idx  <= next_idx;
                        step_wall <= wall_hit;
                        step_grow <= grow;
                        step_self <= self_hit;
                        state     <= S_COMMIT;
                    end
                    S_COMMIT: begin
                        if (step_wall || step_self) begin
                            Collision <= 1'b1;
                            state     <= S_HALT;
                        end else begin
                            // Tail clear comes first so a head moving onto the old tail cell stays set.
                            if (step_grow) begin
                                if (Length < 8'(MAX_LEN))
                                    Length <= Length + 8'd1;
                                Food_Eaten <= 1'b1;
                            end else begin
                                bitmap[body[tail_ptr]] <= 1'b0;
                                tail_ptr               <= ptr_inc(tail_ptr);
                            end
                            bitmap[step_idx] <= 1'b1;
                            head_ptr         <= ptr_inc(head_ptr);
                            Head_X           <= step_x;
                            Head_Y           <= step_y;
                            state            <= S_WAIT;
                        end
                    end
                    S_HALT: state <= S_HALT;
                    default: state <= S_INIT;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (q_I || state == S_INIT) begin
            for (int i = 0; i < INIT_LEN; i++)
                body[8'(i)] <= 8'(HEAD_IDX - INIT_LEN + 1 + i);
        end else if (state == S_COMMIT && !step_wall && !step_self) begin
            body[ptr_inc(head_ptr)] <= step_idx;
        end
    end

endmodule
